// File: rtl/fpu_mul_scheduler.sv
// Two-requester front end for one shared single-precision multiplier.
// Round-robin grant, one operation in flight, sticky exception flag accumulation.
module fpu_mul_scheduler #(
  parameter int unsigned MUL_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [63:0] req_a,
  input  logic [63:0] req_b,
  input  logic [5:0]  req_rm,
  output logic [1:0]  rsp_valid,
  input  logic [1:0]  rsp_ready,
  output logic [31:0] rsp_y,
  output logic [4:0]  rsp_flags,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  output logic [2:0]  mul_rm,
  input  logic [31:0] mul_y,
  input  logic [4:0]  mul_flags,
  output logic        busy,
  output logic [4:0]  fflags,
  input  logic        fflags_clr
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(MUL_LATENCY - 1);

  state_t      r_state, w_state_nxt;
  logic [1:0]  r_rst_sync;
  logic        w_rst_n;
  logic        r_owner;
  logic        r_last;
  logic [3:0]  r_cnt;
  logic        w_grant;
  logic        w_accept;
  logic        w_exec_done;
  logic        w_rsp_hs;

  // NOTE: reset asserts asynchronously but releases only after two clean
  // clock edges, so no flop sees rst_n rise too close to an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rst_sync <= 2'b00;
    else        r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  // With both requesting, the one not served last wins.
  assign w_grant     = (req_valid == 2'b11) ? ~r_last : req_valid[1];
  assign req_ready   = (r_state == S_IDLE && w_rst_n) ?
                       ((w_grant ? 2'b10 : 2'b01) & req_valid) : 2'b00;
  assign w_accept    = |req_ready;
  assign w_exec_done = (r_state == S_EXEC) && (r_cnt == 4'd0);
  assign w_rsp_hs    = (r_state == S_RESP) && rsp_ready[r_owner];
  assign rsp_valid   = (r_state == S_RESP) ? (r_owner ? 2'b10 : 2'b01) : 2'b00;
  assign busy        = (r_state != S_IDLE);

  // NOTE: every variable in a combinational block gets a default first so
  // no path through the case leaves it unassigned (which would infer a latch).
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept)    w_state_nxt = S_EXEC;
      S_EXEC:  if (w_exec_done) w_state_nxt = S_RESP;
      S_RESP:  if (w_rsp_hs)    w_state_nxt = S_IDLE;
      default:                  w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      mul_a   <= '0;
      mul_b   <= '0;
      mul_rm  <= '0;
      r_owner <= 1'b0;
      r_last  <= 1'b1;
      r_cnt   <= '0;
    end else if (w_accept) begin
      mul_a   <= w_grant ? req_a[63:32] : req_a[31:0];
      mul_b   <= w_grant ? req_b[63:32] : req_b[31:0];
      mul_rm  <= w_grant ? req_rm[5:3]  : req_rm[2:0];
      r_owner <= w_grant;
      r_last  <= w_grant;
      r_cnt   <= CNT_LOAD;
    end else if (r_state == S_EXEC && r_cnt != 4'd0) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      rsp_y     <= '0;
      rsp_flags <= '0;
    end else if (w_exec_done) begin
      rsp_y     <= mul_y;
      rsp_flags <= mul_flags;
    end
  end

  // A clear coinciding with a response keeps only that response's flags.
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n)        fflags <= '0;
    else if (fflags_clr) fflags <= w_rsp_hs ? rsp_flags : 5'b00000;
    else if (w_rsp_hs)   fflags <= fflags | rsp_flags;
  end

endmodule

// File: tb/tb_fpu_mul_scheduler.sv
// Directed bench: dut0 runs with MUL_LATENCY=1, dut1 with MUL_LATENCY=3.
// The multiplier is a lookup stub of hand-computed single-precision products.
module tb_fpu_mul_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, fflags_clr, busy;
  logic [1:0]  req_valid, req_ready, rsp_valid, rsp_ready;
  logic [63:0] req_a, req_b;
  logic [5:0]  req_rm;
  logic [31:0] rsp_y, mul_a, mul_b, mul_y;
  logic [4:0]  rsp_flags, mul_flags, fflags;
  logic [2:0]  mul_rm;

  logic        d1_rst_n, d1_fflags_clr, d1_busy;
  logic [1:0]  d1_req_valid, d1_req_ready, d1_rsp_valid, d1_rsp_ready;
  logic [63:0] d1_req_a, d1_req_b;
  logic [5:0]  d1_req_rm;
  logic [31:0] d1_rsp_y, d1_mul_a, d1_mul_b, d1_mul_y;
  logic [4:0]  d1_rsp_flags, d1_mul_flags, d1_fflags;
  logic [2:0]  d1_mul_rm;

  int n_checks = 0;
  int n_fail   = 0;

  fpu_mul_scheduler #(.MUL_LATENCY(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_rm(req_rm), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_y(rsp_y), .rsp_flags(rsp_flags),
    .mul_a(mul_a), .mul_b(mul_b), .mul_rm(mul_rm), .mul_y(mul_y),
    .mul_flags(mul_flags), .busy(busy), .fflags(fflags), .fflags_clr(fflags_clr)
  );

  fpu_mul_scheduler #(.MUL_LATENCY(3)) dut1 (
    .clk(clk), .rst_n(d1_rst_n), .req_valid(d1_req_valid), .req_ready(d1_req_ready),
    .req_a(d1_req_a), .req_b(d1_req_b), .req_rm(d1_req_rm), .rsp_valid(d1_rsp_valid),
    .rsp_ready(d1_rsp_ready), .rsp_y(d1_rsp_y), .rsp_flags(d1_rsp_flags),
    .mul_a(d1_mul_a), .mul_b(d1_mul_b), .mul_rm(d1_mul_rm), .mul_y(d1_mul_y),
    .mul_flags(d1_mul_flags), .busy(d1_busy), .fflags(d1_fflags),
    .fflags_clr(d1_fflags_clr)
  );

  // Returns {flags, product} for the operand pairs used below.
  function automatic logic [36:0] mul_model(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      {32'h4000_0000, 32'h4040_0000}: return {5'b00000, 32'h40C0_0000};
      {32'h3FC0_0000, 32'h3FC0_0000}: return {5'b00000, 32'h4010_0000};
      {32'h4000_0000, 32'h4000_0000}: return {5'b00000, 32'h4080_0000};
      {32'h7F80_0000, 32'h0000_0000}: return {5'b10000, 32'h7FC0_0000};
      {32'h3F80_0001, 32'h3F80_0001}: return {5'b00001, 32'h3F80_0002};
      default:                        return '0;
    endcase
  endfunction

  assign {mul_flags, mul_y}       = mul_model(mul_a, mul_b);
  assign {d1_mul_flags, d1_mul_y} = mul_model(d1_mul_a, d1_mul_b);

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Full single operation on dut0, starting at a negedge with dut0 idle.
  task automatic run_op0(input int idx, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] rm, input logic [31:0] exp_y,
                         input logic [4:0] exp_f, input logic clr);
    logic [1:0] sel;
    sel = (idx == 1) ? 2'b10 : 2'b01;
    if (idx == 1) begin
      req_a[63:32] = a; req_b[63:32] = b; req_rm[5:3] = rm;
    end else begin
      req_a[31:0] = a; req_b[31:0] = b; req_rm[2:0] = rm;
    end
    req_valid = sel;
    #1 check("op_req_ready", 64'(req_ready), 64'(sel));
    @(negedge clk);
    req_valid = 2'b00;
    check("op_exec_busy", 64'(busy), 64'(1'b1));
    check("op_mul_a", 64'(mul_a), 64'(a));
    check("op_mul_rm", 64'(mul_rm), 64'(rm));
    check("op_exec_no_rsp", 64'(rsp_valid), 64'(2'b00));
    @(negedge clk);
    check("op_rsp_valid", 64'(rsp_valid), 64'(sel));
    check("op_rsp_y", 64'(rsp_y), 64'(exp_y));
    check("op_rsp_flags", 64'(rsp_flags), 64'(exp_f));
    rsp_ready  = sel;
    fflags_clr = clr;
    @(negedge clk);
    rsp_ready  = 2'b00;
    fflags_clr = 1'b0;
    check("op_done_rsp_valid", 64'(rsp_valid), 64'(2'b00));
    check("op_done_busy", 64'(busy), 64'(1'b0));
  endtask

  initial begin
    rst_n = 1'b1; req_valid = '0; req_a = '0; req_b = '0; req_rm = '0;
    rsp_ready = '0; fflags_clr = 1'b0;
    d1_rst_n = 1'b1; d1_req_valid = '0; d1_req_a = '0; d1_req_b = '0; d1_req_rm = '0;
    d1_rsp_ready = '0; d1_fflags_clr = 1'b0;

    // Power-on reset values.
    #1 rst_n = 1'b0; d1_rst_n = 1'b0;
    #1;
    check("rst_busy", 64'(busy), 64'(1'b0));
    check("rst_req_ready", 64'(req_ready), 64'(2'b00));
    check("rst_rsp_valid", 64'(rsp_valid), 64'(2'b00));
    check("rst_rsp_y", 64'(rsp_y), 64'(32'h0));
    check("rst_mul_a", 64'(mul_a), 64'(32'h0));
    check("rst_mul_rm", 64'(mul_rm), 64'(3'b000));
    check("rst_fflags", 64'(fflags), 64'(5'b00000));

    // Release is held off for two clock edges.
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1; d1_rst_n = 1'b1;
    req_valid = 2'b01;
    #1 check("sync_hold_0", 64'(req_ready), 64'(2'b00));
    @(negedge clk);
    check("sync_hold_1", 64'(req_ready), 64'(2'b00));
    req_valid = 2'b00;
    @(negedge clk);

    // Basic product 2.0 * 3.0 = 6.0 at latency 1.
    run_op0(0, 32'h4000_0000, 32'h4040_0000, 3'b000, 32'h40C0_0000, 5'b00000, 1'b0);
    check("t1_fflags", 64'(fflags), 64'(5'b00000));

    // Re-reset so last_served returns to 1, then present both requesters.
    rst_n = 1'b0;
    #1;
    check("rst2_mul_a", 64'(mul_a), 64'(32'h0));
    check("rst2_rsp_y", 64'(rsp_y), 64'(32'h0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); @(negedge clk);
    req_a = {32'h4000_0000, 32'h3FC0_0000};
    req_b = {32'h4000_0000, 32'h3FC0_0000};
    req_rm = '0;
    req_valid = 2'b11;
    #1 check("rr_first_grant", 64'(req_ready), 64'(2'b01));
    @(negedge clk);
    check("rr_exec_ready", 64'(req_ready), 64'(2'b00));
    check("rr_exec_mul_a", 64'(mul_a), 64'(32'h3FC0_0000));
    @(negedge clk);
    check("rr_rsp0_valid", 64'(rsp_valid), 64'(2'b01));
    check("rr_rsp0_y", 64'(rsp_y), 64'(32'h4010_0000));
    rsp_ready = 2'b10;
    @(negedge clk);
    check("rr_nonowner_ignored", 64'(rsp_valid), 64'(2'b01));
    check("rr_no_accept_in_resp", 64'(req_ready), 64'(2'b00));
    rsp_ready = 2'b01;
    @(negedge clk);
    rsp_ready = 2'b00;
    #1 check("rr_second_grant", 64'(req_ready), 64'(2'b10));
    check("rr_idle_busy", 64'(busy), 64'(1'b0));
    @(negedge clk);
    check("rr_exec1_mul_a", 64'(mul_a), 64'(32'h4000_0000));
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check("stall_rsp_valid", 64'(rsp_valid), 64'(2'b10));
      check("stall_rsp_y", 64'(rsp_y), 64'(32'h4080_0000));
      check("stall_req_ready", 64'(req_ready), 64'(2'b00));
      check("stall_busy", 64'(busy), 64'(1'b1));
      @(negedge clk);
    end
    check("stall_end_valid", 64'(rsp_valid), 64'(2'b10));
    rsp_ready = 2'b10;
    req_valid = 2'b00;
    @(negedge clk);
    rsp_ready = 2'b00;
    check("stall_done_valid", 64'(rsp_valid), 64'(2'b00));
    check("stall_done_busy", 64'(busy), 64'(1'b0));

    // Sticky flags: invalid then inexact, then clear.
    run_op0(0, 32'h7F80_0000, 32'h0000_0000, 3'b000, 32'h7FC0_0000, 5'b10000, 1'b0);
    check("flags_nv", 64'(fflags), 64'(5'b10000));
    run_op0(1, 32'h3F80_0001, 32'h3F80_0001, 3'b011, 32'h3F80_0002, 5'b00001, 1'b0);
    check("flags_nv_nx", 64'(fflags), 64'(5'b10001));
    fflags_clr = 1'b1;
    @(negedge clk);
    fflags_clr = 1'b0;
    check("flags_cleared", 64'(fflags), 64'(5'b00000));
    run_op0(0, 32'h7F80_0000, 32'h0000_0000, 3'b000, 32'h7FC0_0000, 5'b10000, 1'b0);
    run_op0(1, 32'h3F80_0001, 32'h3F80_0001, 3'b000, 32'h3F80_0002, 5'b00001, 1'b1);
    check("flags_clr_with_hs", 64'(fflags), 64'(5'b00001));

    // Latency 3: response appears on the fourth cycle after the handshake.
    d1_req_a[63:32] = 32'h7F80_0000;
    d1_req_b[63:32] = 32'h0000_0000;
    d1_req_valid = 2'b10;
    #1 check("l3_req_ready", 64'(d1_req_ready), 64'(2'b10));
    @(negedge clk);
    d1_req_valid = 2'b00;
    check("l3_exec1_busy", 64'(d1_busy), 64'(1'b1));
    @(negedge clk);
    check("l3_exec2_no_rsp", 64'(d1_rsp_valid), 64'(2'b00));
    @(negedge clk);
    check("l3_exec3_no_rsp", 64'(d1_rsp_valid), 64'(2'b00));
    @(negedge clk);
    check("l3_rsp_valid", 64'(d1_rsp_valid), 64'(2'b10));
    check("l3_rsp_y", 64'(d1_rsp_y), 64'(32'h7FC0_0000));
    check("l3_rsp_flags", 64'(d1_rsp_flags), 64'(5'b10000));
    d1_rsp_ready = 2'b10;
    @(negedge clk);
    d1_rsp_ready = 2'b00;
    check("l3_fflags", 64'(d1_fflags), 64'(5'b10000));

    // Abort in the second EXEC cycle.
    d1_req_a[31:0] = 32'h4000_0000;
    d1_req_b[31:0] = 32'h4000_0000;
    d1_req_rm[2:0] = 3'b100;
    d1_req_valid = 2'b01;
    #1 check("abort_req_ready", 64'(d1_req_ready), 64'(2'b01));
    @(negedge clk);
    check("abort_exec1_rm", 64'(d1_mul_rm), 64'(3'b100));
    @(negedge clk);
    d1_rst_n = 1'b0;
    #1;
    check("abort_busy", 64'(d1_busy), 64'(1'b0));
    check("abort_req_ready_rst", 64'(d1_req_ready), 64'(2'b00));
    check("abort_rsp_valid", 64'(d1_rsp_valid), 64'(2'b00));
    check("abort_rsp_y", 64'(d1_rsp_y), 64'(32'h0));
    check("abort_rsp_flags", 64'(d1_rsp_flags), 64'(5'b00000));
    check("abort_mul_a", 64'(d1_mul_a), 64'(32'h0));
    check("abort_mul_b", 64'(d1_mul_b), 64'(32'h0));
    check("abort_mul_rm", 64'(d1_mul_rm), 64'(3'b000));
    check("abort_fflags", 64'(d1_fflags), 64'(5'b00000));
    d1_req_valid = 2'b00;
    @(negedge clk); @(negedge clk);
    d1_rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("abort_no_rsp", 64'(d1_rsp_valid), 64'(2'b00));
      check("abort_idle", 64'(d1_busy), 64'(1'b0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fpu_mul_scheduler.md
FPU_MUL_SCHEDULER -- requirements
Module: fpu_mul_scheduler

Interface
REQ-001 SHALL have parameter MUL_LATENCY, default 1, meaning cycles from operand presentation to valid mul_y/mul_flags; legal range 1..15.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port req_valid  input  2  bit i = requester i presents an operation.
REQ-005 SHALL have port req_ready  output  2  bit i = requester i accepted this cycle.
REQ-006 SHALL have port req_a  input  64  operand A, {req1, req0}, IEEE-754 single.
REQ-007 SHALL have port req_b  input  64  operand B, {req1, req0}.
REQ-008 SHALL have port req_rm  input  6  rounding mode, {req1, req0}, 3 bits each (000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM).
REQ-009 SHALL have port rsp_valid  output  2  bit i = result for requester i available.
REQ-010 SHALL have port rsp_ready  input  2  bit i = requester i takes its result.
REQ-011 SHALL have port rsp_y  output  32  result word, shared by both requesters.
REQ-012 SHALL have port rsp_flags  output  5  {NV,DZ,OF,UF,NX} of the result.
REQ-013 SHALL have ports mul_a/mul_b  output  32 each  operands to the shared multiplier datapath.
REQ-014 SHALL have port mul_rm  output  3  rounding mode to the multiplier.
REQ-015 SHALL have ports mul_y  input  32  and  mul_flags  input  5  multiplier result and flags.
REQ-016 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-017 SHALL have ports fflags  output  5  sticky accumulated flags, and fflags_clr  input  1  clears fflags.

Function
REQ-018 SHALL implement FSM states IDLE, EXEC, RESP; one operation in flight at most.
REQ-019 In IDLE, grant SHALL be round-robin: a single valid requester wins; with both valid, the requester not served last wins; last_served resets to 1, so requester 0 wins first.
REQ-020 req_ready[i] SHALL be high only in IDLE with grant to i; it may depend on req_valid. Outside IDLE req_ready = 2'b00.
REQ-021 On handshake (req_valid[i] & req_ready[i]), the block SHALL register req_a/req_b/req_rm slice i into mul_a/mul_b/mul_rm, record owner=i, update last_served=i, load latency counter, and enter EXEC.
REQ-022 mul_a/mul_b/mul_rm SHALL be register outputs, held stable through EXEC and RESP, retaining last values in IDLE.
REQ-023 EXEC SHALL last exactly MUL_LATENCY cycles; in its last cycle mul_y/mul_flags SHALL be captured into rsp_y/rsp_flags, then RESP is entered.
REQ-024 Timing: handshake at cycle T -> EXEC cycles T+1..T+MUL_LATENCY -> rsp_valid[owner] high from T+MUL_LATENCY+1.
REQ-025 In RESP, rsp_valid SHALL be one-hot at owner, with rsp_y/rsp_flags stable until rsp_ready[owner] is sampled high; then state goes to IDLE the next cycle. rsp_ready of the non-owner SHALL be ignored.
REQ-026 Peak throughput SHALL be one operation per MUL_LATENCY+2 cycles; no new accept is permitted in the RESP handshake cycle.
REQ-027 On the response handshake, fflags SHALL become fflags | rsp_flags.
REQ-028 fflags_clr SHALL zero fflags next cycle; if a response handshake coincides, fflags = rsp_flags only.
REQ-029 A requester deasserting req_valid without a handshake SHALL cause no state change; grant is re-evaluated each IDLE cycle.

Reset
REQ-030 rst_n low SHALL immediately force: state IDLE, req_ready 0, rsp_valid 0, busy 0, rsp_y 0, rsp_flags 0, mul_a/mul_b 0, mul_rm 000, fflags 0, counter 0, last_served 1.
REQ-031 Reset during EXEC or RESP SHALL abort the operation; no response is ever issued for it.
REQ-032 Deassertion of rst_n SHALL be synchronised internally before use by the state register (two-flop release).

Verification
REQ-033 MUL_LATENCY=1, req0: a=0x40000000, b=0x40400000, rm=000; mul model returns product -> rsp_valid=2'b01 at T+2, rsp_y=0x40C00000, rsp_flags=00000.
REQ-034 Both valid in the same cycle after reset: req0 a=b=0x3FC00000, req1 a=0x40000000 b=0x40000000 -> req0 served first (rsp_y 0x40100000), then req1 (rsp_y 0x40800000).
REQ-035 rsp_ready held low 5 cycles in RESP -> rsp_valid, rsp_y held; req_ready stays 2'b00; busy=1 throughout.
REQ-036 Operation with mul_flags=10000 (inf*0), then NX-only op (00001) -> fflags=10001; pulse fflags_clr -> fflags=00000.
REQ-037 MUL_LATENCY=3, assert rst_n low in second EXEC cycle -> all outputs reset values immediately, no rsp_valid after release.
